// File: rtl/complex_mult_bram_v2_if.sv
// rtl/complex_mult_bram_v2_if.sv - stream, reference BRAM and control bundle for complex_mult_bram_v2
interface complex_mult_bram_v2_if #(
   parameter int DATA_W          = 16,
   parameter int REF_W           = 16,
   parameter int OUT_W           = 32,
   parameter int BRAM_DEPTH_BITS = 10
);
   logic [2*DATA_W-1:0]        s00_axis_tdata;
   logic                       s00_axis_tvalid;
   logic                       s00_axis_tready;
   logic                       s00_axis_tlast;
   logic [2*OUT_W-1:0]         m00_axis_tdata;
   logic                       m00_axis_tvalid;
   logic                       m00_axis_tready;
   logic                       m00_axis_tlast;
   logic [2*OUT_W/8-1:0]       m00_axis_tstrb;
   logic [BRAM_DEPTH_BITS-1:0] bram_addr;
   logic [2*REF_W-1:0]         bram_datain;
   logic                       conj_en;
   logic [BRAM_DEPTH_BITS-1:0] frame_last;
   logic                       sat_flag;
   logic                       frame_done;

   modport slave (
      input  s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast, m00_axis_tready,
             bram_datain, conj_en, frame_last,
      output s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast,
             m00_axis_tstrb, bram_addr, sat_flag, frame_done
   );

   modport master (
      output s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast, m00_axis_tready,
             bram_datain, conj_en, frame_last,
      input  s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast,
             m00_axis_tstrb, bram_addr, sat_flag, frame_done
   );
endinterface

// File: rtl/complex_mult_bram_v2.sv
// rtl/complex_mult_bram_v2.sv - streaming complex multiplier against a frame-indexed BRAM reference
// Three-stage pipeline (capture, products, sum/round/saturate) advancing together on en.
module complex_mult_bram_v2 #(
   parameter int DATA_W          = 16,
   parameter int REF_W           = 16,
   parameter int OUT_W           = 32,
   parameter int SHIFT           = 0,
   parameter int BRAM_DEPTH_BITS = 10
) (
   input logic                   s00_axis_aclk,
   input logic                   s00_axis_areset,
   complex_mult_bram_v2_if.slave bus
);
   localparam int PROD_W = DATA_W + REF_W;
   localparam int SUM_W  = PROD_W + 1;
   localparam int WIDE_W = ((SUM_W + 1 > OUT_W) ? SUM_W + 1 : OUT_W) + 1;
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [WIDE_W-1:0] RND     = (SHIFT > 0) ? (WIDE_W'(1) <<< RND_SH) : '0;
   localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic                       en, accept, s_ready, wrap, conj_eff;
   logic [BRAM_DEPTH_BITS-1:0] idx, idx_next, fl_eff, mode_fl;
   logic                       mode_conj;

   logic                       v1, l1, c1;
   logic signed [DATA_W-1:0]   s1_ar, s1_ai;
   logic signed [REF_W-1:0]    s1_br, s1_bi;
   logic                       v2, l2, c2;
   logic signed [PROD_W-1:0]   p_rr, p_ii, p_ri, p_ir;
   logic                       v3, out_last, sat, fd;
   logic [2*OUT_W-1:0]         out_data;

   logic signed [SUM_W-1:0]    sum_re, sum_im;
   logic [OUT_W:0]             res_re, res_im;

   // Returns {saturated, value} after rounding and arithmetic shift.
   function automatic logic [OUT_W:0] round_sat(input logic signed [SUM_W-1:0] s);
      logic signed [WIDE_W-1:0] w;
      w = (WIDE_W'(s) + RND) >>> SHIFT;
      if (w > SAT_MAX)
         return {1'b1, SAT_MAX[OUT_W-1:0]};
      else if (w < SAT_MIN)
         return {1'b1, SAT_MIN[OUT_W-1:0]};
      else
         return {1'b0, w[OUT_W-1:0]};
   endfunction

   always_comb begin
      en       = !v3 || bus.m00_axis_tready;
      s_ready  = en && !s00_axis_areset;
      accept   = bus.s00_axis_tvalid && s_ready;
      // The first sample of a frame uses the mode being latched alongside it.
      fl_eff   = (idx == '0) ? bus.frame_last : mode_fl;
      conj_eff = (idx == '0) ? bus.conj_en : mode_conj;
      wrap     = bus.s00_axis_tlast || (idx == fl_eff);
      idx_next = wrap ? '0 : idx + BRAM_DEPTH_BITS'(1);
   end

   // Presenting the next index during accept lets bram_datain line up with ref[idx].
   assign bus.bram_addr       = s00_axis_areset ? '0 : (accept ? idx_next : idx);
   assign bus.s00_axis_tready = s_ready;
   assign bus.m00_axis_tvalid = v3;
   assign bus.m00_axis_tdata  = out_data;
   assign bus.m00_axis_tlast  = out_last;
   assign bus.m00_axis_tstrb  = '1;
   assign bus.sat_flag        = sat;
   assign bus.frame_done      = fd;

   always_comb begin
      if (c2) begin
         sum_re = SUM_W'(p_rr) + SUM_W'(p_ii);
         sum_im = SUM_W'(p_ir) - SUM_W'(p_ri);
      end else begin
         sum_re = SUM_W'(p_rr) - SUM_W'(p_ii);
         sum_im = SUM_W'(p_ri) + SUM_W'(p_ir);
      end
      res_re = round_sat(sum_re);
      res_im = round_sat(sum_im);
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         idx       <= '0;
         mode_conj <= 1'b0;
         mode_fl   <= '1;
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         l1        <= 1'b0;
         l2        <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         sat       <= 1'b0;
         fd        <= 1'b0;
      end else begin
         fd <= accept && wrap;
         if (accept) begin
            idx <= idx_next;
            if (idx == '0) begin
               mode_conj <= bus.conj_en;
               mode_fl   <= bus.frame_last;
            end
         end
         if (en) begin
            v1    <= accept;
            s1_ar <= bus.s00_axis_tdata[DATA_W-1:0];
            s1_ai <= bus.s00_axis_tdata[2*DATA_W-1:DATA_W];
            s1_br <= bus.bram_datain[REF_W-1:0];
            s1_bi <= bus.bram_datain[2*REF_W-1:REF_W];
            l1    <= bus.s00_axis_tlast;
            c1    <= conj_eff;

            v2   <= v1;
            l2   <= l1;
            c2   <= c1;
            p_rr <= PROD_W'(s1_ar) * PROD_W'(s1_br);
            p_ii <= PROD_W'(s1_ai) * PROD_W'(s1_bi);
            p_ri <= PROD_W'(s1_ar) * PROD_W'(s1_bi);
            p_ir <= PROD_W'(s1_ai) * PROD_W'(s1_br);

            v3       <= v2;
            out_last <= l2;
            out_data <= {res_im[OUT_W-1:0], res_re[OUT_W-1:0]};
            if (v2 && (res_re[OUT_W] || res_im[OUT_W]))
               sat <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_complex_mult_bram_v2.sv
// tb/tb_complex_mult_bram_v2.sv - scoreboard bench for complex_mult_bram_v2
module tb_complex_mult_bram_v2;
   localparam int DATA_W = 16;
   localparam int REF_W  = 16;
   localparam int OUT_W  = 32;
   localparam int BDB    = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   complex_mult_bram_v2_if #(.DATA_W(DATA_W), .REF_W(REF_W), .OUT_W(OUT_W), .BRAM_DEPTH_BITS(BDB)) bus ();

   complex_mult_bram_v2 #(.DATA_W(DATA_W), .REF_W(REF_W), .OUT_W(OUT_W), .SHIFT(0), .BRAM_DEPTH_BITS(BDB)) dut (
      .s00_axis_aclk   (clk),
      .s00_axis_areset (rst),
      .bus             (bus)
   );

   logic [31:0] ref_mem [0:1023];
   always @(posedge clk) bus.bram_datain <= ref_mem[bus.bram_addr];

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          fd_cnt = 0;
   int          idx_m = 0;
   int          mfl = 1023;
   bit          mconj = 1'b0;
   logic [64:0] sb [$];
   logic [64:0] exp_w;
   logic [63:0] prev_d;
   logic        prev_l;
   bit          prev_stall = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sat32(input longint v);
      if (v > 64'sd2147483647)
         return 32'h7fffffff;
      if (v < -64'sd2147483648)
         return 32'h80000000;
      return v[31:0];
   endfunction

   function automatic logic [63:0] model_prod(input logic [31:0] s, input logic [31:0] r, input bit cj);
      longint ar, ai, br, bi, re, im;
      ar = longint'($signed(s[15:0]));
      ai = longint'($signed(s[31:16]));
      br = longint'($signed(r[15:0]));
      bi = longint'($signed(r[31:16]));
      if (cj) begin
         re = ar * br + ai * bi;
         im = ai * br - ar * bi;
      end else begin
         re = ar * br - ai * bi;
         im = ar * bi + ai * br;
      end
      return {sat32(im), sat32(re)};
   endfunction

   task automatic send(input logic [15:0] i, input logic [15:0] q, input bit last);
      bit done = 1'b0;
      bit wrap;
      int nxt;
      bus.s00_axis_tdata  = {q, i};
      bus.s00_axis_tlast  = last;
      bus.s00_axis_tvalid = 1'b1;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (bus.s00_axis_tready) begin
            if (idx_m == 0) begin
               mconj = bus.conj_en;
               mfl   = int'(bus.frame_last);
            end
            wrap = last || (idx_m == mfl);
            nxt  = wrap ? 0 : idx_m + 1;
            check("bram_addr", bus.bram_addr, nxt);
            sb.push_back({last, model_prod({q, i}, ref_mem[idx_m], mconj)});
            idx_m = nxt;
            @(posedge clk);
            #1;
            check("frame_done", bus.frame_done, wrap);
            done = 1'b1;
         end
      end
      if (!done)
         check("s_tready_timeout", 0, 1);
      bus.s00_axis_tvalid = 1'b0;
      bus.s00_axis_tlast  = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 100 && sb.size() != 0; t++) begin
         @(posedge clk);
         #1;
      end
      check("drain", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rnd16();
      return 16'($urandom_range(0, 4000)) - 16'd2000;
   endfunction

   always @(negedge clk) begin
      if (bus.frame_done)
         fd_cnt++;
      if (rst) begin
         prev_stall = 1'b0;
      end else if (bus.m00_axis_tvalid) begin
         if (prev_stall) begin
            check("stall_tdata", bus.m00_axis_tdata, prev_d);
            check("stall_tlast", bus.m00_axis_tlast, prev_l);
         end
         if (bus.m00_axis_tready) begin
            prev_stall = 1'b0;
            if (sb.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               exp_w = sb.pop_front();
               check("m_tdata", bus.m00_axis_tdata, exp_w[63:0]);
               check("m_tlast", bus.m00_axis_tlast, exp_w[64]);
            end
         end else begin
            check("stall_s_tready", bus.s00_axis_tready, 0);
            prev_d     = bus.m00_axis_tdata;
            prev_l     = bus.m00_axis_tlast;
            prev_stall = 1'b1;
         end
      end else begin
         if (prev_stall)
            check("stall_tvalid", 0, 1);
         prev_stall = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      for (int i = 0; i < 1024; i++)
         ref_mem[i] = {rnd16(), rnd16()};
      ref_mem[0] = {16'd4, 16'd3};
      bus.s00_axis_tdata  = '0;
      bus.s00_axis_tvalid = 1'b0;
      bus.s00_axis_tlast  = 1'b0;
      bus.m00_axis_tready = 1'b1;
      bus.conj_en         = 1'b0;
      bus.frame_last      = '1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s_tready", bus.s00_axis_tready, 0);
      check("rst_m_tvalid", bus.m00_axis_tvalid, 0);
      check("rst_m_tlast", bus.m00_axis_tlast, 0);
      check("rst_m_tdata", bus.m00_axis_tdata, 0);
      check("rst_sat_flag", bus.sat_flag, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_bram_addr", bus.bram_addr, 0);
      check("m_tstrb", bus.m00_axis_tstrb, 8'hff);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("s_tready_after_rst", bus.s00_axis_tready, 1);
      @(posedge clk);
      #1;

      // basic multiply and latency, plain then conjugate
      bus.conj_en = 1'b0;
      send(16'd1, 16'd2, 1'b1);
      @(negedge clk);
      check("latency_c1", bus.m00_axis_tvalid, 0);
      @(negedge clk);
      check("latency_c2", bus.m00_axis_tvalid, 0);
      @(negedge clk);
      check("latency_c3", bus.m00_axis_tvalid, 1);
      wait_drain();
      bus.conj_en = 1'b1;
      send(16'd1, 16'd2, 1'b1);
      wait_drain();

      // wrap at frame_last=3
      bus.conj_en    = 1'b0;
      bus.frame_last = 10'd3;
      fd_cnt = 0;
      c0 = cyc;
      for (int k = 0; k < 6; k++)
         send(rnd16(), rnd16(), 1'b0);
      check("throughput", cyc - c0, 6);
      wait_drain();
      check("wrap_fd_count", fd_cnt, 1);
      send(rnd16(), rnd16(), 1'b1);
      wait_drain();

      // early tlast within a frame_last=7 frame
      bus.frame_last = 10'd7;
      fd_cnt = 0;
      for (int k = 0; k < 5; k++)
         send(rnd16(), rnd16(), k == 2);
      wait_drain();
      check("early_fd_count", fd_cnt, 1);
      send(rnd16(), rnd16(), 1'b1);
      wait_drain();

      // backpressure mid-stream
      bus.frame_last = '1;
      fork
         begin
            for (int k = 0; k < 10; k++)
               send(rnd16(), rnd16(), k == 9);
         end
         begin
            repeat (4) @(posedge clk);
            #1 bus.m00_axis_tready = 1'b0;
            repeat (5) @(posedge clk);
            #1 bus.m00_axis_tready = 1'b1;
         end
      join
      wait_drain();

      // saturation and sticky flag
      bus.conj_en = 1'b1;
      ref_mem[0] = {16'h8000, 16'h8000};
      repeat (2) @(posedge clk);
      #1;
      send(16'h8000, 16'h8000, 1'b0);
      wait_drain();
      check("sat_flag_set", bus.sat_flag, 1);
      send(16'd5, 16'd6, 1'b0);
      send(16'd7, 16'd8, 1'b1);
      wait_drain();
      check("sat_flag_sticky", bus.sat_flag, 1);
      ref_mem[0] = {16'd4, 16'd3};
      repeat (2) @(posedge clk);
      #1;

      // reset with three samples in flight from idx 5
      bus.conj_en = 1'b0;
      for (int k = 0; k < 5; k++)
         send(rnd16(), rnd16(), 1'b0);
      wait_drain();
      bus.m00_axis_tready = 1'b0;
      for (int k = 0; k < 3; k++)
         send(rnd16(), rnd16(), 1'b0);
      rst = 1'b1;
      sb.delete();
      idx_m = 0;
      mconj = 1'b0;
      mfl   = 1023;
      @(posedge clk);
      repeat (2) begin
         @(negedge clk);
         check("midrst_m_tvalid", bus.m00_axis_tvalid, 0);
         check("midrst_s_tready", bus.s00_axis_tready, 0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      bus.conj_en = 1'b1;
      bus.m00_axis_tready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("postrst_m_tvalid", bus.m00_axis_tvalid, 0);
         check("postrst_bram_addr", bus.bram_addr, 0);
      end
      check("postrst_sat_flag", bus.sat_flag, 0);
      @(posedge clk);
      #1;
      send(16'd9, 16'hfffd, 1'b1);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
